// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard controller: load-use stall, MUL/DIV occupancy, branch flush
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             idex_memrd,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mdu,
  input  logic             ex_branch_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mdu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             mdu_busy
);

  localparam int CW = $clog2(MDU_LAT);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lu_hit;

  // x0 is hard-wired zero, so a load to it can never create a dependency
  assign lu_hit = idex_memrd && (idex_rd != 5'd0) &&
                  ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_busy     = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (idex_mdu) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            state_nxt    = MDU_WAIT;
            cnt_nxt      = CW'(MDU_LAT - 2);
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          mdu_busy     = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else cnt_nxt = cnt - CW'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Stall/flush causes are recovered from the mutually exclusive output patterns
  logic lu_stall, mdu_stall, br_flush;
  assign lu_stall  = idex_flush && !ifid_flush;
  assign mdu_stall = exmem_bubble;
  assign br_flush  = ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      mdu_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu_stall && (lu_stall_cnt != '1))   lu_stall_cnt  <= lu_stall_cnt + 1'b1;
      if (mdu_stall && (mdu_stall_cnt != '1)) mdu_stall_cnt <= mdu_stall_cnt + 1'b1;
      if (br_flush && (flush_cnt != '1))      flush_cnt     <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized + directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs1, ifid_use_rs2, idex_memrd, idex_mdu, ex_branch_taken;
  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, mdu_busy;
  logic [6:0] act, got;

  int total = 0;
  int bad   = 0;
  int mdu_left = 0;

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, mdu_busy}
  localparam logic [6:0] V_RST = 7'b0001100;
  localparam logic [6:0] V_RUN = 7'b1110000;
  localparam logic [6:0] V_LU  = 7'b0010100;
  localparam logic [6:0] V_BR  = 7'b1111100;
  localparam logic [6:0] V_M0  = 7'b0000010;
  localparam logic [6:0] V_MW  = 7'b0000011;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_stall_cnt, mdu_stall_cnt, flush_cnt;
  longint m_lu = 0, m_mdu = 0, m_fl = 0;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_memrd(idex_memrd), .idex_rd(idex_rd), .idex_mdu(idex_mdu),
    .ex_branch_taken(ex_branch_taken),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .mdu_stall_cnt(mdu_stall_cnt), .flush_cnt(flush_cnt),
`endif
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .mdu_busy(mdu_busy)
  );

  assign act = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, mdu_busy};

  // Drive one cycle of inputs, then check outputs against the behavioural model mid-cycle.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic memrd,
                      input logic [4:0] rd, input logic mdu, input logic br,
                      output logic [6:0] g);
    logic [6:0] exp;
    logic lu;
    @(posedge clk);
    #1;
    rst_n = r; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_use_rs1 = u1; ifid_use_rs2 = u2;
    idex_memrd = memrd; idex_rd = rd; idex_mdu = mdu; ex_branch_taken = br;
    @(negedge clk);
    lu = memrd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r) begin
      exp = V_RST;
      mdu_left = 0;
    end else if (mdu_left > 0) begin
      exp = V_MW;
      mdu_left--;
    end else if (mdu) begin
      exp = V_M0;
      mdu_left = MDU_LAT - 1;
    end else if (br)  exp = V_BR;
    else if (lu)      exp = V_LU;
    else              exp = V_RUN;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL model_outputs t=%0t got=%b exp=%b", $time, act, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (!r) begin m_lu = 0; m_mdu = 0; m_fl = 0; end
    total++;
    if (lu_stall_cnt !== CNT_W'(m_lu) || mdu_stall_cnt !== CNT_W'(m_mdu) || flush_cnt !== CNT_W'(m_fl)) begin
      bad++;
      $display("FAIL model_counters t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
               lu_stall_cnt, mdu_stall_cnt, flush_cnt, m_lu, m_mdu, m_fl);
    end
    if (r) begin
      if (exp == V_LU) m_lu++;
      if (exp == V_M0 || exp == V_MW) m_mdu++;
      if (exp == V_BR) m_fl++;
    end
`endif
    g = act;
  endtask

  task automatic lit(input string name, input logic [6:0] g, input logic [6:0] exp);
    total++;
    if (g !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, g, exp);
    end
  endtask

  task automatic nop(output logic [6:0] g);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, g);
  endtask

  initial begin
    rst_n = 1'b0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_memrd = 0; idex_rd = 0; idex_mdu = 0; ex_branch_taken = 0;

    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, got);
    lit("reset_outputs", got, V_RST);
    nop(got); lit("run_default", got, V_RUN);

    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, got);
    lit("lu_rs1_stall", got, V_LU);
    nop(got); lit("lu_one_cycle", got, V_RUN);
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, got);
    lit("lu_rs2_unused", got, V_RUN);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, got);
    lit("lu_rd_zero", got, V_RUN);
    step(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, got);
    lit("lu_both_match", got, V_LU);
    nop(got); lit("lu_both_single", got, V_RUN);

    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, got);
    lit("mdu_first", got, V_M0);
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, got);
      lit("mdu_wait", got, V_MW);
    end
    nop(got); lit("mdu_done", got, V_RUN);

    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, got);
    lit("branch_over_lu", got, V_BR);
    nop(got); lit("branch_no_stall", got, V_RUN);

    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, got);
    lit("mdu_over_branch", got, V_M0);
    nop(got); lit("mdu_wait1", got, V_MW);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, got);
    lit("rst_in_wait", got, V_RST);
    nop(got); lit("rst_release_run", got, V_RUN);

`ifdef HAZARD_PERF_CNT_EN
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, got);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, got);
      nop(got);
    end
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, got);
    for (int i = 0; i < MDU_LAT; i++) nop(got);
    total++;
    if (lu_stall_cnt !== 3) begin bad++; $display("FAIL perf_lu got=%0d exp=3", lu_stall_cnt); end
    total++;
    if (mdu_stall_cnt !== 4) begin bad++; $display("FAIL perf_mdu got=%0d exp=4", mdu_stall_cnt); end
`endif

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) != 0),
           5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           5'($urandom_range(3)), ($urandom_range(9) == 0), ($urandom_range(5) == 0), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
